// File: rtl/nx_msg_arbiter.sv
// Round-robin arbiter sharing one registered nx_message_t egress among INPUTS requesters.
// Optional per-requester grant counters are enabled with `define NX_ARB_STATS_EN.

package nx_pkg;
  typedef struct packed {
    logic [7:0]  dst;
    logic [3:0]  kind;
    logic [31:0] payload;
  } nx_message_t;
endpackage

module nx_msg_arbiter
  import nx_pkg::*;
#(
  parameter int INPUTS    = 4,
  parameter int SRC_WIDTH = ($clog2(INPUTS) > 0 ? $clog2(INPUTS) : 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  nx_message_t [INPUTS-1:0]      inbound_data_i,
  input  logic        [INPUTS-1:0]      inbound_valid_i,
  output logic        [INPUTS-1:0]      inbound_ready_o,
  output nx_message_t                   outbound_data_o,
  output logic        [SRC_WIDTH-1:0]   outbound_source_o,
  output logic                          outbound_valid_o,
  input  logic                          outbound_ready_i,
  output logic                          idle_o
`ifdef NX_ARB_STATS_EN
  ,
  input  logic                          stats_clear_i,
  output logic [INPUTS-1:0][15:0]       stats_grants_o
`endif
);

  localparam logic [SRC_WIDTH:0] NUM_REQ = (SRC_WIDTH+1)'(INPUTS);

  logic [SRC_WIDTH-1:0] ptr_r;
  logic [SRC_WIDTH-1:0] grant_idx_s;
  logic                 grant_found_s;
  logic [SRC_WIDTH:0]   sum_s;
  logic [SRC_WIDTH:0]   cand_s;
  logic                 can_accept_s;
  logic                 xfer_s;

  assign can_accept_s = !outbound_valid_o | outbound_ready_i;
  assign xfer_s       = can_accept_s & grant_found_s;
  assign idle_o       = !outbound_valid_o & ~|inbound_valid_i;

  // Rotating search from the slot after the last grant; sum never exceeds 2*INPUTS-1.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    sum_s         = '0;
    cand_s        = '0;
    for (int k = 1; k <= INPUTS; k++) begin
      sum_s  = {1'b0, ptr_r} + (SRC_WIDTH+1)'(k);
      cand_s = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
      if (!grant_found_s && inbound_valid_i[cand_s[SRC_WIDTH-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[SRC_WIDTH-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Ready is returned only to the granted requester, and only when the register can take it.
  always_comb begin
    inbound_ready_o = '0;
    if (xfer_s) begin
      inbound_ready_o[grant_idx_s] = 1'b1;
    end else begin
      inbound_ready_o = '0;
    end
  end

  // Output register and last-grant pointer; a pop with a same-cycle grant reloads in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outbound_valid_o  <= 1'b0;
      outbound_data_o   <= '0;
      outbound_source_o <= '0;
      ptr_r             <= SRC_WIDTH'(INPUTS - 1);
    end else if (xfer_s) begin
      outbound_valid_o  <= 1'b1;
      outbound_data_o   <= inbound_data_i[grant_idx_s];
      outbound_source_o <= grant_idx_s;
      ptr_r             <= grant_idx_s;
    end else if (outbound_valid_o && outbound_ready_i) begin
      outbound_valid_o  <= 1'b0;
    end else begin
      outbound_valid_o  <= outbound_valid_o;
    end
  end

`ifdef NX_ARB_STATS_EN
  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stats_grants_o <= '0;
    end else if (stats_clear_i) begin
      stats_grants_o <= '0;
    end else if (xfer_s && (stats_grants_o[grant_idx_s] != 16'hFFFF)) begin
      stats_grants_o[grant_idx_s] <= stats_grants_o[grant_idx_s] + 16'd1;
    end else begin
      stats_grants_o <= stats_grants_o;
    end
  end
`endif

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Scoreboard bench for nx_msg_arbiter: a round-robin reference model predicts grants and
// pushes expected messages; an independent monitor checks every presented output.

module tb_nx_msg_arbiter;
  import nx_pkg::*;

  localparam int N  = 4;
  localparam int SW = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  nx_message_t [N-1:0]  in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  nx_message_t          out_data;
  logic [SW-1:0]        out_src;
  logic                 out_valid;
  logic                 out_ready;
  logic                 idle;
`ifdef NX_ARB_STATS_EN
  logic                 stats_clear;
  logic [N-1:0][15:0]   stats_grants;
  int                   m_cnt [N];
`endif

  typedef struct packed {
    nx_message_t   msg;
    logic [SW-1:0] src;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     m_ptr;
  bit     m_occ;
  bit     regen [N];

  always #5 clk = ~clk;

  nx_msg_arbiter #(.INPUTS(N)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .inbound_data_i    (in_data),
    .inbound_valid_i   (in_valid),
    .inbound_ready_o   (in_ready),
    .outbound_data_o   (out_data),
    .outbound_source_o (out_src),
    .outbound_valid_o  (out_valid),
    .outbound_ready_i  (out_ready),
    .idle_o            (idle)
`ifdef NX_ARB_STATS_EN
    ,
    .stats_clear_i     (stats_clear),
    .stats_grants_o    (stats_grants)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic nx_message_t rand_msg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[$bits(nx_message_t)-1:0];
  endfunction

  // One cycle: drive inputs at negedge, predict with the model, check combinational outputs.
  task automatic step(input logic [N-1:0] vmask, input logic rdy);
    bit   can;
    int   g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (regen[i]) begin
        in_data[i] = rand_msg();
        regen[i] = 1'b0;
      end
    end
    in_valid  = vmask;
    out_ready = rdy;
    #1;
    can = !m_occ || rdy;
    g   = -1;
    for (int k = 1; k <= N; k++) begin
      if (g < 0 && vmask[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_rdy = '0;
    if (can && g >= 0) exp_rdy[g] = 1'b1;
    chk("inbound_ready", 64'(in_ready), 64'(exp_rdy));
    chk("outbound_valid", 64'(out_valid), 64'(m_occ));
    chk("idle", 64'(idle), 64'(!m_occ && vmask == '0));
`ifdef NX_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stats_grants", 64'(stats_grants[i]), 64'(m_cnt[i]));
    if (stats_clear) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (can && g >= 0 && m_cnt[g] < 65535) begin
      m_cnt[g]++;
    end
`endif
    if (can && g >= 0) begin
      exp_q.push_back('{msg: in_data[g], src: SW'(g)});
      m_ptr    = g;
      m_occ    = 1'b1;
      regen[g] = 1'b1;
    end else if (m_occ && rdy) begin
      m_occ = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = N - 1;
    m_occ = 1'b0;
`ifdef NX_ARB_STATS_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endtask

  // Monitor: every cycle the output is valid it must match the oldest expected message.
  always @(negedge clk) begin
    #2;
    if (rst_ni && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL outbound_unexpected: got source %0d with nothing expected", out_src);
      end else begin
        chk("outbound_data", 64'(out_data), 64'(exp_q[0].msg));
        chk("outbound_source", 64'(out_src), 64'(exp_q[0].src));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    in_valid  = '0;
    out_ready = 1'b0;
`ifdef NX_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      in_data[i] = rand_msg();
      regen[i]   = 1'b0;
    end
    model_reset();
    #12;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    chk("reset_source", 64'(out_src), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd0);
    #11 rst_ni = 1'b1;

    // Idle, single requester, then park the pointer at 3.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b1);
    // Fair rotation over all requesters.
    repeat (8) step(4'b1111, 1'b1);
    // Wrap with sparse requesters 1 and 3.
    repeat (3) step(4'b1010, 1'b1);
    // Backpressure then release.
    repeat (5) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);

    // Asynchronous reset while the output is valid.
    @(negedge clk);
    #3;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    in_valid = '0;
    model_reset();
    @(negedge clk);
    #3 rst_ni = 1'b1;
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

`ifdef NX_ARB_STATS_EN
    repeat (3) step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    chk("stats_three_grants", 64'(stats_grants[1]), 64'd3);
    stats_clear = 1'b1;
    step(4'b0010, 1'b1);
    stats_clear = 1'b0;
    step(4'b0000, 1'b1);
    chk("stats_clear_wins", 64'(stats_grants[1]), 64'd0);
`endif

    // Randomized traffic with random backpressure and withdrawals.
    for (int c = 0; c < 600; c++) begin
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(4'b0000, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
